// File: rtl/sme_scheduler.sv
// Two-requester front end for a byte-serial string matching engine: buffers one job,
// replays string and pattern to the engine, and returns the engine result (or a timeout).
module sme_scheduler #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_ispat,
    input  logic [1:0]  req_last,
    output logic [1:0]  rsp_valid,
    output logic        rsp_match,
    output logic [4:0]  rsp_index,
    output logic        rsp_err,
    output logic [7:0]  eng_chardata,
    output logic        eng_isstring,
    output logic        eng_ispattern,
    input  logic        eng_valid,
    input  logic        eng_match,
    input  logic [4:0]  eng_match_index
);
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int SIW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY_STR, PLAY_PAT, WAIT, RESP} state_t;
    state_t state;

    logic           g, rr_ptr, str_ok, job_err, seen_pat;
    logic           res_match, res_err;
    logic [4:0]     res_index;
    logic [SW-1:0]  str_cnt, str_len, str_cnt_nx;
    logic [PW-1:0]  pat_cnt, pat_cnt_nx;
    logic [SIW-1:0] k;
    logic [TW-1:0]  wcnt;
    logic [7:0]     strbuf [STR_MAX];
    logic [7:0]     patbuf [PAT_MAX];

    logic       xfer, b_pat, b_last, str_wr, pat_wr, byte_err, end_err;
    logic [7:0] b_data;

    // Handshake: a byte moves on a rising edge where req_valid[g] & req_ready[g];
    // req_ready is high only for the granted requester and only while in LOAD.
    assign xfer = |(req_valid & req_ready);

    always_comb begin
        b_data     = g ? req_data[15:8] : req_data[7:0];
        b_pat      = req_ispat[g];
        b_last     = req_last[g];
        str_wr     = xfer && !b_pat && !seen_pat && (str_cnt < SW'(STR_MAX));
        pat_wr     = xfer && b_pat && (pat_cnt < PW'(PAT_MAX));
        byte_err   = xfer && !str_wr && !pat_wr;
        str_cnt_nx = str_cnt + SW'(str_wr);
        pat_cnt_nx = pat_cnt + PW'(pat_wr);
        // A job with no string bytes replays the previous string, which must be intact.
        end_err    = job_err || byte_err || (pat_cnt_nx == '0) ||
                     ((str_cnt_nx == '0) && !str_ok);
    end

    always_ff @(posedge clk) begin
        if (str_wr) strbuf[str_cnt[SIW-1:0]] <= b_data;
        if (pat_wr) patbuf[pat_cnt[PIW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            g         <= 1'b0;
            rr_ptr    <= 1'b0;
            str_ok    <= 1'b0;
            job_err   <= 1'b0;
            seen_pat  <= 1'b0;
            str_cnt   <= '0;
            pat_cnt   <= '0;
            str_len   <= '0;
            k         <= '0;
            wcnt      <= '0;
            res_match <= 1'b0;
            res_index <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    if (&req_valid) begin
                        g      <= rr_ptr;
                        rr_ptr <= ~rr_ptr;
                    end else begin
                        g <= req_valid[1];
                    end
                    job_err  <= 1'b0;
                    seen_pat <= 1'b0;
                    str_cnt  <= '0;
                    pat_cnt  <= '0;
                    state    <= LOAD;
                end
                LOAD: if (xfer) begin
                    str_cnt <= str_cnt_nx;
                    pat_cnt <= pat_cnt_nx;
                    if (b_pat) seen_pat <= 1'b1;
                    if (byte_err) job_err <= 1'b1;
                    if (str_wr) begin
                        str_ok  <= 1'b0;
                        str_len <= str_cnt_nx;
                    end
                    if (b_last) begin
                        k <= '0;
                        if (end_err) begin
                            res_match <= 1'b0;
                            res_index <= '0;
                            res_err   <= 1'b1;
                            state     <= RESP;
                        end else if (str_cnt_nx != '0) begin
                            state <= PLAY_STR;
                        end else begin
                            state <= PLAY_PAT;
                        end
                    end
                end
                PLAY_STR: begin
                    if (SW'(k) == str_len - SW'(1)) begin
                        k      <= '0;
                        str_ok <= 1'b1;
                        state  <= PLAY_PAT;
                    end else begin
                        k <= k + SIW'(1);
                    end
                end
                PLAY_PAT: begin
                    if (PW'(k[PIW-1:0]) == pat_cnt - PW'(1)) begin
                        wcnt  <= '0;
                        state <= WAIT;
                    end else begin
                        k <= k + SIW'(1);
                    end
                end
                WAIT: begin
                    if (eng_valid) begin
                        res_match <= eng_match;
                        res_index <= eng_match_index;
                        res_err   <= 1'b0;
                        state     <= RESP;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        res_match <= 1'b0;
                        res_index <= '0;
                        res_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so reset clears them asynchronously.
    always_comb begin
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        rsp_match     = 1'b0;
        rsp_index     = 5'd0;
        rsp_err       = 1'b0;
        eng_chardata  = 8'h00;
        eng_isstring  = 1'b0;
        eng_ispattern = 1'b0;
        case (state)
            LOAD: req_ready[g] = 1'b1;
            PLAY_STR: begin
                eng_isstring = 1'b1;
                eng_chardata = strbuf[k];
            end
            PLAY_PAT: begin
                eng_ispattern = 1'b1;
                eng_chardata  = patbuf[k[PIW-1:0]];
            end
            RESP: begin
                rsp_valid[g] = 1'b1;
                rsp_match    = res_match;
                rsp_index    = res_index;
                rsp_err      = res_err;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sme_scheduler.sv
// Directed bench for sme_scheduler: requester drivers, an engine responder, and a
// response scoreboard fed by hand-computed expectations.
module tb_sme_scheduler;
    localparam int TIMEOUT = 40;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        rv [2];
    logic [7:0]  rd [2];
    logic        rp [2];
    logic        rl [2];
    logic [1:0]  req_valid, req_ready, req_ispat, req_last, rsp_valid;
    logic [15:0] req_data;
    logic        rsp_match, rsp_err;
    logic [4:0]  rsp_index;
    logic [7:0]  eng_chardata;
    logic        eng_isstring, eng_ispattern;
    logic        eng_valid, eng_match;
    logic [4:0]  eng_match_index;

    assign req_valid = {rv[1], rv[0]};
    assign req_data  = {rd[1], rd[0]};
    assign req_ispat = {rp[1], rp[0]};
    assign req_last  = {rl[1], rl[0]};

    sme_scheduler dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_ispat(req_ispat), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_index(rsp_index), .rsp_err(rsp_err),
        .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
        .eng_valid(eng_valid), .eng_match(eng_match), .eng_match_index(eng_match_index)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    int nstr = 0, npat = 0, first_str = 0, last_str = 0, first_pat = 0, last_pat = 0;
    int eng_idle_bad = 0, rsp_idle_bad = 0;
    byte_q_t str_seen, pat_seen;
    logic [8:0] exp_q[$];

    logic       eng_auto = 1'b1;
    int         eng_delay = 2;
    logic       eng_m = 1'b0;
    logic [4:0] eng_i = 5'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input byte_q_t q);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[55:0], q[i]};
        return v;
    endfunction

    task automatic clear_trace();
        nstr = 0; npat = 0;
        first_str = 0; last_str = 0; first_pat = 0; last_pat = 0;
        str_seen.delete();
        pat_seen.delete();
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic p, input logic l);
        int n = 0;
        rv[r] = 1'b1; rd[r] = d; rp[r] = p; rl[r] = l;
        while (!req_ready[r] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(req_ready[r]), 64'd1);
        @(negedge clk);
        rv[r] = 1'b0; rl[r] = 1'b0;
    endtask

    task automatic send_job(input int r, input string s, input string p);
        for (int i = 0; i < s.len(); i++) push_byte(r, s[i], 1'b0, 1'b0);
        for (int i = 0; i < p.len(); i++) push_byte(r, p[i], 1'b1, i == p.len() - 1);
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int t = 0;
        while (rsp_cnt < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(rsp_cnt), 64'(target));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Engine responder: answers a fixed number of cycles after the pattern ends.
    initial begin
        logic pat_prev = 1'b0;
        eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0;
        forever begin
            @(negedge clk);
            if (pat_prev && !eng_ispattern && eng_auto && reset) begin
                repeat (eng_delay) @(negedge clk);
                eng_valid = 1'b1; eng_match = eng_m; eng_match_index = eng_i;
                @(negedge clk);
                eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0;
            end
            pat_prev = eng_ispattern;
        end
    end

    // Monitor and scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (eng_isstring) begin
                    if (nstr == 0) first_str = cyc;
                    last_str = cyc; nstr++;
                    str_seen.push_back(eng_chardata);
                end
                if (eng_ispattern) begin
                    if (npat == 0) first_pat = cyc;
                    last_pat = cyc; npat++;
                    pat_seen.push_back(eng_chardata);
                end
                if ((eng_isstring && eng_ispattern) ||
                    (!eng_isstring && !eng_ispattern && eng_chardata != 8'h00)) eng_idle_bad++;
                if (rsp_valid == 2'b00) begin
                    if (rsp_match || rsp_err || rsp_index != 5'd0) rsp_idle_bad++;
                end else begin
                    rsp_cyc = cyc;
                    rsp_cnt++;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'({rsp_valid, rsp_match, rsp_index, rsp_err}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", 64'({rsp_valid, rsp_match, rsp_index, rsp_err}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        int base, t;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rd[i] = 8'h00; rp[i] = 1'b0; rl[i] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({req_ready, rsp_valid, rsp_match, rsp_index, rsp_err, eng_chardata, eng_isstring, eng_ispattern}),
              64'd0);
        reset = 1'b1;
        @(negedge clk);

        // "abcd" + "bc" from requester 0, engine reports match at 1
        clear_trace();
        eng_m = 1'b1; eng_i = 5'd1; base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b1, 5'd1, 1'b0});
        send_job(0, "abcd", "bc");
        wait_rsp(base + 1, "t1_rsp_count");
        check("t1_nstr", 64'(nstr), 64'd4);
        check("t1_str_contig", 64'(last_str - first_str + 1), 64'd4);
        check("t1_pat_follows", 64'(first_pat), 64'(last_str + 1));
        check("t1_npat", 64'(npat), 64'd2);
        check("t1_str_bytes", pack(str_seen), 64'h61626364);
        check("t1_pat_bytes", pack(pat_seen), 64'h6263);

        // pattern-only reuse from requester 1
        clear_trace();
        eng_m = 1'b1; eng_i = 5'd0; base = rsp_cnt;
        exp_q.push_back({2'b10, 1'b1, 5'd0, 1'b0});
        send_job(1, "", "ab");
        wait_rsp(base + 1, "t2_rsp_count");
        check("t2_nstr", 64'(nstr), 64'd0);
        check("t2_npat", 64'(npat), 64'd2);
        check("t2_pat_bytes", pack(pat_seen), 64'h6162);

        // engine silent: timeout exactly TIMEOUT cycles after WAIT entry
        clear_trace();
        eng_auto = 1'b0; base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd0, 1'b1});
        send_job(0, "ab", "b");
        wait_rsp(base + 1, "t5_rsp_count");
        check("t5_timeout_cycles", 64'(rsp_cyc - last_pat - 1), 64'(TIMEOUT));
        eng_auto = 1'b1;

        // round robin after reset: 0 then 1, then 1 then 0
        do_reset();
        eng_m = 1'b1; eng_i = 5'd1; base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b1, 5'd1, 1'b0});
        exp_q.push_back({2'b10, 1'b1, 5'd1, 1'b0});
        fork
            send_job(0, "xy", "y");
            send_job(1, "pq", "q");
        join
        wait_rsp(base + 2, "t3a_rsp_count");
        base = rsp_cnt;
        exp_q.push_back({2'b10, 1'b1, 5'd1, 1'b0});
        exp_q.push_back({2'b01, 1'b1, 5'd1, 1'b0});
        fork
            send_job(0, "xy", "y");
            send_job(1, "pq", "q");
        join
        wait_rsp(base + 2, "t3b_rsp_count");

        // reset in the middle of requester 1's PLAY_STR, pointer then favouring 1
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b1, 5'd1, 1'b0});
        fork
            send_job(0, "ab", "b");
            send_job(1, "abcdefgh", "h");
        join
        check("t6_first_rsp", 64'(rsp_cnt), 64'(base + 1));
        t = 0;
        while (!eng_isstring && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_playstr_seen", 64'(eng_isstring), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_async_eng", 64'({eng_isstring, eng_ispattern, eng_chardata}), 64'd0);
        check("t6_async_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b1, 5'd1, 1'b0});
        exp_q.push_back({2'b10, 1'b1, 5'd1, 1'b0});
        fork
            send_job(0, "cd", "d");
            send_job(1, "ef", "f");
        join
        wait_rsp(base + 2, "t6_rsp_count");

        // error jobs and buffer limits
        do_reset();
        clear_trace();
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd0, 1'b1});
        send_job(0, "", "z");
        wait_rsp(base + 1, "t4a_rsp_count");
        check("t4a_no_drive", 64'(nstr + npat), 64'd0);

        clear_trace();
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd0, 1'b1});
        send_job(0, "abcdefghijklmnopqrstuvwxyz0123456", "1");
        wait_rsp(base + 1, "t4b_rsp_count");
        check("t4b_no_drive", 64'(nstr + npat), 64'd0);

        clear_trace();
        eng_m = 1'b1; eng_i = 5'd31; base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b1, 5'd31, 1'b0});
        send_job(0, "abcdefghijklmnopqrstuvwxyz012345", "5");
        wait_rsp(base + 1, "t4c_rsp_count");
        check("t4c_nstr", 64'(nstr), 64'd32);
        check("t4c_str_tail", pack(str_seen), 64'h797a303132333435);
        check("t4c_npat", 64'(npat), 64'd1);

        clear_trace();
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd0, 1'b1});
        send_job(0, "", "abcdefghi");
        wait_rsp(base + 1, "t4d_rsp_count");
        check("t4d_no_drive", 64'(nstr + npat), 64'd0);

        clear_trace();
        eng_m = 1'b0; eng_i = 5'd18; base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd18, 1'b0});
        send_job(0, "", "stuvwxyz");
        wait_rsp(base + 1, "t4e_rsp_count");
        check("t4e_nstr", 64'(nstr), 64'd0);
        check("t4e_pat_bytes", pack(pat_seen), 64'h737475767778797a);

        clear_trace();
        base = rsp_cnt;
        exp_q.push_back({2'b01, 1'b0, 5'd0, 1'b1});
        push_byte(0, 8'h70, 1'b1, 1'b0);
        push_byte(0, 8'h73, 1'b0, 1'b1);
        wait_rsp(base + 1, "t4f_rsp_count");
        check("t4f_no_drive", 64'(nstr + npat), 64'd0);

        check("eng_idle_zero", 64'(eng_idle_bad), 64'd0);
        check("rsp_idle_zero", 64'(rsp_idle_bad), 64'd0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sme_scheduler.md
SME_SCHEDULER -- requirements
Module: sme_scheduler

Interface
REQ-001 SHALL have parameter STR_MAX, 32, maximum string bytes per job.
REQ-002 SHALL have parameter PAT_MAX, 8, maximum pattern bytes per job.
REQ-003 SHALL have parameter TIMEOUT, 40, maximum WAIT cycles before an engine result is abandoned.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  2  per-requester byte valid.
REQ-007 SHALL have port req_ready  output  2  per-requester byte accept.
REQ-008 SHALL have port req_data  input  16  byte for requester i on bits [8i+7:8i].
REQ-009 SHALL have port req_ispat  input  2  1 = pattern byte, 0 = string byte.
REQ-010 SHALL have port req_last  input  2  marks the final byte of a job.
REQ-011 SHALL have port rsp_valid  output  2  one-cycle result pulse to requester i.
REQ-012 SHALL have ports rsp_match (output, 1), rsp_index (output, 5) and rsp_err (output, 1), shared by both requesters and qualified by rsp_valid.
REQ-013 SHALL have ports eng_chardata (output, 8), eng_isstring (output, 1) and eng_ispattern (output, 1), the byte-serial drive to the matching engine.
REQ-014 SHALL have ports eng_valid (input, 1), eng_match (input, 1) and eng_match_index (input, 5), the engine result.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, PLAY_STR, PLAY_PAT, WAIT and RESP.
REQ-016 IDLE SHALL grant the single requester with req_valid=1; if both are valid, it SHALL grant the one the round-robin pointer favours and then point the pointer at the other, moving to LOAD on the next cycle.
REQ-017 LOAD SHALL assert only req_ready[g]; a byte SHALL transfer on req_valid[g]&req_ready[g]; string bytes SHALL fill strbuf and pattern bytes SHALL fill patbuf, in order.
REQ-018 Job format: zero or more string bytes, then one or more pattern bytes, with last on the final pattern byte.
REQ-019 LOAD SHALL continue accepting bytes after an error until last, setting a sticky job_err; error causes:
- a string byte arriving after a pattern byte;
- more than STR_MAX string bytes or PAT_MAX pattern bytes (excess bytes dropped);
- zero pattern bytes;
- zero string bytes while str_ok=0.
REQ-020 Any job that writes one or more string bytes SHALL clear str_ok and store str_len.
REQ-021 On the transfer of the last byte, LOAD SHALL go to RESP if job_err=1, else to PLAY_STR if str_len_job>0, else to PLAY_PAT (string reuse).
REQ-022 PLAY_STR SHALL drive eng_isstring=1 and eng_chardata=strbuf[k] for k=0..str_len-1, one byte per cycle with no gaps, then enter PLAY_PAT directly; it SHALL set str_ok=1 on completion.
REQ-023 PLAY_PAT SHALL drive eng_ispattern=1 with patbuf[0..pat_len-1] on consecutive cycles, then enter WAIT.
REQ-024 Outside PLAY_STR and PLAY_PAT, eng_isstring and eng_ispattern SHALL be 0 and eng_chardata SHALL be 8'h00.
REQ-025 WAIT SHALL count cycles from 0; on the first cycle with eng_valid=1, it SHALL capture eng_match and eng_match_index and go to RESP with err=0.
REQ-026 If the WAIT count reaches TIMEOUT, WAIT SHALL go to RESP with rsp_err=1, rsp_match=0 and rsp_index=0.
REQ-027 eng_valid SHALL be ignored outside WAIT.
REQ-028 RESP SHALL pulse rsp_valid[g] for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-029 When rsp_valid is 0, rsp_match, rsp_index and rsp_err SHALL be 0.
REQ-030 A new grant SHALL occur no earlier than the cycle after RESP.
REQ-031 req_valid of the non-granted requester SHALL have no effect until IDLE.

Reset
REQ-032 Asserting reset (low) in any state SHALL immediately return the FSM to IDLE and clear: str_ok, job_err, counters, req_ready, rsp_* and eng_* outputs; the round-robin pointer SHALL be set to favour requester 0.
REQ-033 Buffer contents after reset SHALL be don't-care; because str_ok=0, a reuse job issued after reset SHALL return rsp_err=1.
REQ-034 A reset asserted during PLAY_STR or PLAY_PAT SHALL deassert eng_isstring and eng_ispattern asynchronously.

Verification
REQ-035 Directed test: requester 0 sends the string "abcd" plus the pattern "bc", and the engine model returns match=1, index=1 -> eng_isstring high for 4 consecutive cycles, then eng_ispattern high for 2, then rsp_valid=2'b01, rsp_match=1, rsp_index=5'd1.
REQ-036 Directed test: both requesters are valid in the same IDLE cycle after reset -> requester 0 is served first, then requester 1; both being valid again -> requester 1 is served before requester 0.
REQ-037 Directed test: after a completed job, requester 1 sends the pattern "ab" only -> no eng_isstring cycles, eng_ispattern for 2 cycles, and a normal response.
REQ-038 Directed test: reset, then a pattern-only job -> rsp_err=1, and eng_isstring and eng_ispattern never assert; a 33-byte string plus a 1-byte pattern -> rsp_err=1 with no engine drive.
REQ-039 Directed test: eng_valid held 0 after PLAY_PAT -> rsp_valid is asserted exactly TIMEOUT cycles after entering WAIT, with rsp_err=1.
REQ-040 Directed test: reset pulsed low in the middle of PLAY_STR -> all eng_* and req_ready go 0 within the same cycle, and the next job is granted to requester 0.
